// File: rtl/spi_flash_id_responder.sv
// spi_flash_id_responder
//
// SPI mode-0 slave that stands in for a serial flash answering the RDID
// command. After the 8-bit command it returns a 24-bit identification word,
// MSB first. All SPI pins are oversampled on clk, and no logic runs on SPICLK.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   SPICLK       SPI clock from the master (mode 0, idle low), asynchronous
//   SPIMOSI      serial data from the master, MSB first
//   chip_select  active-low slave select
//   SPIMISO      serial data to the master; 0 whenever not responding
//   cmd_byte     last complete command byte received
//   cmd_valid    one-clk pulse when cmd_byte updates
//   rdid_done    one-clk pulse when the 24th response bit is driven
//   busy         registered inverse of synchronized chip_select
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | deselected (or not yet armed); counters and shifters cleared
// CMD    | shifting in the command byte on SPICLK rises
// RESP   | shifting out the ID word on SPICLK falls
// IGNORE | command done or not recognised; wait for deselect

module spi_flash_id_responder #(
    parameter logic [7:0] MANUFACTURER_ID = 8'h20,
    parameter logic [7:0] MEMORY_TYPE     = 8'h20,
    parameter logic [7:0] MEMORY_CAPACITY = 8'h15,
    parameter logic [7:0] RDID_OPCODE     = 8'h9F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       chip_select,
    output logic       SPIMISO,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic       rdid_done,
    output logic       busy
);

    localparam logic [23:0] ID_WORD = {MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAPACITY};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RESP   = 2'd2,
        IGNORE = 2'd3
    } state_t;

    logic       sclk_meta, sclk_s, sclk_d;
    logic       mosi_meta, mosi_s;
    logic       cs_meta, cs_s;
    logic       sclk_rise, sclk_fall;
    logic [1:0] settle;
    logic       armed;

    state_t      state, nxt_state;
    logic [4:0]  bit_cnt, nxt_cnt;
    logic [7:0]  cmd_sr, nxt_cmd_sr;
    logic [7:0]  cmd_shifted;
    logic [23:0] tx_sr, nxt_tx;
    logic        nxt_miso;
    logic [7:0]  nxt_cmd_byte;
    logic        nxt_cmd_valid;
    logic        nxt_done;

    // Synchronizers, registered edge pulses and the arming logic.
    // The chip_select synchronizer resets to "deselected", so right after
    // reset cs_s reads 1 before the pin value has reached it. settle marks
    // when the chain holds real pin samples; only a genuine deselect seen
    // after that arms the slave, which makes a transaction that was already
    // running at reset release invisible until the next select.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            settle    <= 2'b00;
            armed     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_meta <= SPICLK;
            sclk_s    <= sclk_meta;
            sclk_d    <= sclk_s;
            mosi_meta <= SPIMOSI;
            mosi_s    <= mosi_meta;
            cs_meta   <= chip_select;
            cs_s      <= cs_meta;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            settle    <= {settle[0], 1'b1};
            if (settle[1] && cs_s) begin
                armed <= 1'b1;
            end
            busy      <= ~cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            cmd_sr    <= 8'h00;
            tx_sr     <= 24'h000000;
            SPIMISO   <= 1'b0;
            cmd_byte  <= 8'h00;
            cmd_valid <= 1'b0;
            rdid_done <= 1'b0;
        end else begin
            state     <= nxt_state;
            bit_cnt   <= nxt_cnt;
            cmd_sr    <= nxt_cmd_sr;
            tx_sr     <= nxt_tx;
            SPIMISO   <= nxt_miso;
            cmd_byte  <= nxt_cmd_byte;
            cmd_valid <= nxt_cmd_valid;
            rdid_done <= nxt_done;
        end
    end

    assign cmd_shifted = {cmd_sr[6:0], mosi_s};

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = bit_cnt;
        nxt_cmd_sr    = cmd_sr;
        nxt_tx        = tx_sr;
        nxt_miso      = SPIMISO;
        nxt_cmd_byte  = cmd_byte;
        nxt_cmd_valid = 1'b0;
        nxt_done      = 1'b0;

        case (state)
            IDLE: begin
                nxt_cnt    = 5'd0;
                nxt_cmd_sr = 8'h00;
                nxt_tx     = 24'h000000;
                nxt_miso   = 1'b0;
                if (armed && !cs_s) begin
                    nxt_state = CMD;
                end
            end

            CMD: begin
                if (cs_s) begin
                    nxt_state = IDLE;
                    nxt_miso  = 1'b0;
                end else if (sclk_rise) begin
                    nxt_cmd_sr = cmd_shifted;
                    nxt_cnt    = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        nxt_cmd_byte  = cmd_shifted;
                        nxt_cmd_valid = 1'b1;
                        nxt_cnt       = 5'd0;
                        if (cmd_shifted == RDID_OPCODE) begin
                            nxt_state = RESP;
                            nxt_tx    = ID_WORD;
                        end else begin
                            nxt_state = IGNORE;
                        end
                    end
                end
            end

            RESP: begin
                if (cs_s) begin
                    nxt_state = IDLE;
                    nxt_miso  = 1'b0;
                end else if (sclk_fall) begin
                    // bit_cnt counts bits already driven; the fall after the
                    // 24th bit parks the line low and ends the response.
                    if (bit_cnt == 5'd24) begin
                        nxt_state = IGNORE;
                        nxt_miso  = 1'b0;
                    end else begin
                        nxt_miso = tx_sr[23];
                        nxt_tx   = {tx_sr[22:0], 1'b0};
                        nxt_cnt  = bit_cnt + 5'd1;
                        nxt_done = (bit_cnt == 5'd23);
                    end
                end
            end

            IGNORE: begin
                nxt_miso = 1'b0;
                if (cs_s) begin
                    nxt_state = IDLE;
                end
            end

            default: begin
                nxt_state = IDLE;
                nxt_miso  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Testbench for spi_flash_id_responder.
// Two instances share one SPI bus: one with the default ID (20/20/15) and one
// with an overridden ID (C2/22/17). The master side is modelled here with
// SPICLK half-period of 8 clk; the master samples SPIMISO at each SPICLK rise.

module tb_spi_flash_id_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       chip_select;

    logic       miso_a, miso_b;
    logic [7:0] cmd_byte_a, cmd_byte_b;
    logic       cmd_valid_a, cmd_valid_b;
    logic       rdid_done_a, rdid_done_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    int n_cv_a = 0, n_cv_b = 0, n_done_a = 0, n_done_b = 0;

    always #5 clk = ~clk;

    spi_flash_id_responder u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .SPICLK      (SPICLK),
        .SPIMOSI     (SPIMOSI),
        .chip_select (chip_select),
        .SPIMISO     (miso_a),
        .cmd_byte    (cmd_byte_a),
        .cmd_valid   (cmd_valid_a),
        .rdid_done   (rdid_done_a),
        .busy        (busy_a)
    );

    spi_flash_id_responder #(
        .MANUFACTURER_ID (8'hC2),
        .MEMORY_TYPE     (8'h22),
        .MEMORY_CAPACITY (8'h17)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .SPICLK      (SPICLK),
        .SPIMOSI     (SPIMOSI),
        .chip_select (chip_select),
        .SPIMISO     (miso_b),
        .cmd_byte    (cmd_byte_b),
        .cmd_valid   (cmd_valid_b),
        .rdid_done   (rdid_done_b),
        .busy        (busy_b)
    );

    always @(posedge clk) begin
        if (cmd_valid_a === 1'b1) n_cv_a   <= n_cv_a + 1;
        if (cmd_valid_b === 1'b1) n_cv_b   <= n_cv_b + 1;
        if (rdid_done_a === 1'b1) n_done_a <= n_done_a + 1;
        if (rdid_done_b === 1'b1) n_done_b <= n_done_b + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Results of the most recent transfer
    logic [31:0] got_a, got_b;
    logic        seen_a, seen_b;   // OR of SPIMISO over every clk of a phase
    logic        busy_mid_a, busy_mid_b;
    int          base_cv_a, base_cv_b, base_done_a, base_done_b;

    task automatic sclk_cycle(input logic mosi_bit, input logic record);
        SPIMOSI = mosi_bit;
        repeat (8) begin
            @(negedge clk);
            seen_a = seen_a | miso_a;
            seen_b = seen_b | miso_b;
        end
        SPICLK = 1'b1;
        if (record) begin
            got_a = {got_a[30:0], miso_a};
            got_b = {got_b[30:0], miso_b};
        end
        repeat (8) begin
            @(negedge clk);
            seen_a = seen_a | miso_a;
            seen_b = seen_b | miso_b;
        end
        SPICLK = 1'b0;
    endtask

    task automatic snap_counts();
        base_cv_a   = n_cv_a;
        base_cv_b   = n_cv_b;
        base_done_a = n_done_a;
        base_done_b = n_done_b;
    endtask

    // One transaction: command byte, then nbits response clocks, then deselect.
    task automatic xfer(input logic [7:0] cmd, input int nbits);
        snap_counts();
        got_a = '0;
        got_b = '0;
        @(negedge clk);
        chip_select = 1'b0;
        repeat (8) @(negedge clk);
        busy_mid_a = busy_a;
        busy_mid_b = busy_b;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int i = 7; i >= 0; i--) sclk_cycle(cmd[i], 1'b0);
        for (int i = 0; i < nbits; i++) sclk_cycle(1'b0, 1'b1);
        repeat (8) @(negedge clk);
        chip_select = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          nbits;
        logic [31:0] exp_resp_a;
        logic [31:0] exp_resp_b;
        int          exp_done;
    } vec_t;

    vec_t vecs [8];

    logic cmd_seen_a, cmd_seen_b;

    initial begin
        vecs[0] = '{8'h9F, 25, 32'h0040_402A, 32'h0184_442E, 1}; // full ID plus one extra clock (0)
        vecs[1] = '{8'h9F, 24, 32'h0020_2015, 32'h00C2_2217, 1}; // back-to-back RDID
        vecs[2] = '{8'h05, 24, 32'h0000_0000, 32'h0000_0000, 0}; // non-RDID
        vecs[3] = '{8'h9F, 12, 32'h0000_0202, 32'h0000_0C22, 0}; // truncated after 12 bits
        vecs[4] = '{8'h9F, 24, 32'h0020_2015, 32'h00C2_2217, 1}; // full after truncated
        vecs[5] = '{8'h9E, 24, 32'h0000_0000, 32'h0000_0000, 0}; // one bit off the opcode
        vecs[6] = '{8'hFF, 24, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[7] = '{8'h00,  8, 32'h0000_0000, 32'h0000_0000, 0};

        // Reset held with the SPI pins active
        reset       = 1'b1;
        chip_select = 1'b0;
        SPICLK      = 1'b1;
        SPIMOSI     = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_miso_a",   {31'd0, miso_a}, 32'd0);
        chk("rst_miso_b",   {31'd0, miso_b}, 32'd0);
        chk("rst_cmd_a",    {24'd0, cmd_byte_a}, 32'h00);
        chk("rst_busy_a",   {31'd0, busy_a}, 32'd0);
        chk("rst_busy_b",   {31'd0, busy_b}, 32'd0);
        chk("rst_cv_cnt",   n_cv_a + n_cv_b, 32'd0);
        chk("rst_done_cnt", n_done_a + n_done_b, 32'd0);

        chip_select = 1'b1;
        SPICLK      = 1'b0;
        SPIMOSI     = 1'b0;
        reset       = 1'b0;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            xfer(vecs[v].cmd, vecs[v].nbits);
            chk($sformatf("v%0d_cmd_a", v),  {24'd0, cmd_byte_a}, {24'd0, vecs[v].cmd});
            chk($sformatf("v%0d_cmd_b", v),  {24'd0, cmd_byte_b}, {24'd0, vecs[v].cmd});
            chk($sformatf("v%0d_cv_a", v),   n_cv_a - base_cv_a, 32'd1);
            chk($sformatf("v%0d_cv_b", v),   n_cv_b - base_cv_b, 32'd1);
            chk($sformatf("v%0d_resp_a", v), got_a, vecs[v].exp_resp_a);
            chk($sformatf("v%0d_resp_b", v), got_b, vecs[v].exp_resp_b);
            chk($sformatf("v%0d_done_a", v), n_done_a - base_done_a, vecs[v].exp_done);
            chk($sformatf("v%0d_done_b", v), n_done_b - base_done_b, vecs[v].exp_done);
            chk($sformatf("v%0d_busy_mid", v), {30'd0, busy_mid_a, busy_mid_b}, 32'd3);
            chk($sformatf("v%0d_idle", v), {29'd0, busy_a, miso_a, miso_b}, 32'd0);
            if (vecs[v].exp_done == 0) begin
                // No response at all for non-RDID; for truncated RDID the
                // collected bits already cover the line
                if (vecs[v].cmd != 8'h9F) begin
                    chk($sformatf("v%0d_miso_quiet", v), {30'd0, seen_a, seen_b}, 32'd0);
                end
            end
        end

        // Reset pulsed in the middle of the command byte
        snap_counts();
        got_a = '0;
        got_b = '0;
        @(negedge clk);
        chip_select = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 7; i >= 4; i--) sclk_cycle(1'(8'h9F >> i), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_a",  {24'd0, cmd_byte_a}, 32'h00);
        chk("midrst_cmd_b",  {24'd0, cmd_byte_b}, 32'h00);
        chk("midrst_busy",   {30'd0, busy_a, busy_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int i = 3; i >= 0; i--) sclk_cycle(1'(8'h9F >> i), 1'b0);
        for (int i = 0; i < 24; i++) sclk_cycle(1'b0, 1'b1);
        cmd_seen_a = seen_a;
        cmd_seen_b = seen_b;
        repeat (8) @(negedge clk);
        chip_select = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_cv",    (n_cv_a - base_cv_a) + (n_cv_b - base_cv_b), 32'd0);
        chk("abort_done",  (n_done_a - base_done_a) + (n_done_b - base_done_b), 32'd0);
        chk("abort_resp",  got_a | got_b, 32'd0);
        chk("abort_quiet", {30'd0, cmd_seen_a, cmd_seen_b}, 32'd0);
        chk("abort_cmd",   {24'd0, cmd_byte_a}, 32'h00);

        xfer(8'h9F, 24);
        chk("post_cmd_a",  {24'd0, cmd_byte_a}, 32'h9F);
        chk("post_cv_a",   n_cv_a - base_cv_a, 32'd1);
        chk("post_resp_a", got_a, 32'h0020_2015);
        chk("post_resp_b", got_b, 32'h00C2_2217);
        chk("post_done_a", n_done_a - base_done_a, 32'd1);
        chk("post_done_b", n_done_b - base_done_b, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
